nes_btn_events: RTL and testbench
=================================

Name: nes_btn_events

Overview:
Downstream consumer of the NES controller interface. It samples the 8-bit button word once per controller frame and debounces it across frames. It publishes a stable pressed-state vector and queues per-button press/release events in a small FIFO, read by the MicroBlaze GPIO/AXI glue through a valid/ready handshake.

Parameters:
DEBOUNCE_FRAMES, 2, consecutive identical frame samples required before a new button vector is accepted (1..15)
FIFO_DEPTH, 8, event FIFO entries (power of 2, 2..64)
FIFO_AW, 3, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-low reset
nes_latch  input  1  latch strobe from the controller interface, asynchronous to sampling logic
nes_btns  input  8  raw button word, active-low; bit7 A, 6 B, 5 Select, 4 Start, 3 Up, 2 Down, 1 Left, 0 Right
btn_state  output  8  debounced state, active-high (1 = pressed), same bit order
evt_valid  output  1  FIFO non-empty
evt_data  output  4  head entry {press, idx[2:0]}; press=1 press, 0 release
evt_ready  input  1  consumer pops head when evt_valid & evt_ready
evt_count  output  FIFO_AW+1  entries currently queued
overflow  output  1  sticky: an event was dropped because the FIFO was full
overflow_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (reset=0, async) clears: sync flops, btn_state=0, candidate=0, frame count=0, FIFO empty (evt_valid=0, evt_count=0, evt_data=0), overflow=0, scanner IDLE, pending=0.
- nes_latch passes through a 2-flop synchronizer plus one delay flop. sample_pulse = sync & ~delay, asserted 3 clk after the rising edge. On sample_pulse, raw = ~nes_btns is captured. The word then holds the fully completed previous frame.
- Debounce on each sample: new_cnt = (raw==candidate) ? min(cnt+1, DEBOUNCE_FRAMES) : 1; candidate<=raw; cnt<=new_cnt.
- Accept when new_cnt==DEBOUNCE_FRAMES and raw!=btn_state. Then: change<=raw^btn_state, btn_state<=raw on the next clk, and the scanner enters SCAN.
- Scanner FSM, IDLE/SCAN:
  - SCAN walks idx 7 down to 0, one idx per clk, 8 clk total, then returns to IDLE.
  - When change[idx]=1 it pushes {btn_state[idx], idx}. Events therefore appear in descending bit order.
- A sample_pulse arriving during SCAN is stored in a one-deep pending register (raw value + flag). It is processed in the first IDLE cycle. A second sample during SCAN overwrites pending.
- FIFO: registered head output; push and pop are independent.
  - Push when full with no pop in the same cycle: the entry is dropped and overflow<=1.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Pop when empty: ignored.
  - overflow_clr and a drop in the same cycle: overflow stays 1 (set wins).
- Pointers wrap modulo FIFO_DEPTH. evt_count saturates naturally at FIFO_DEPTH.
- Latency: latch rise to btn_state update is 4 clk. The first event is visible on evt_valid at 6 clk (accept, scan idx7 push, FIFO register).
- Reset asserted mid-SCAN aborts the scan. Partial events are discarded with the FIFO.

Decomposition:
- Shared package nes_pkg: button bit indices (BTN_A=7 … BTN_RIGHT=0), event field positions (EVT_PRESS=3, EVT_IDX=2:0), scanner state encodings.
- One sub-module: nes_evt_fifo (parameterised sync FIFO with count and full/empty), instantiated once.

Test Plan:
1. Reset state: assert reset=0 mid-run -> btn_state=8'h00, evt_valid=0, evt_count=0, overflow=0 immediately (async).
2. Single press: nes_btns=8'h7F across 2 latch rises -> after the 2nd rise, btn_state=8'h80 at +4 clk, evt_data=4'hF (press A); pop -> evt_valid=0.
3. Glitch rejection: one frame of 8'hFE, then 8'hFF -> no event, btn_state stays 8'h00.
4. Multi-button: 8'h7E for 2 frames -> events 4'hF then 4'h8. Then 8'hFF for 2 frames -> events 4'h7 then 4'h0. evt_count peaks at 2 with no reads.
5. Overflow: evt_ready=0, toggle all 8 buttons, then release 2 -> evt_count=8, overflow=1, first 8 entries intact. overflow_clr -> overflow=0. A full FIFO with simultaneous push and pop keeps count=8.
6. Latch spacing 2 clk, forcing a sample during SCAN -> pending sample processed after SCAN, no events lost or duplicated.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared constants for the NES button event block.
// Button indices, event field positions, scanner states.
package nes_pkg;

   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   localparam int EVT_PRESS   = 3;
   localparam int EVT_IDX_MSB = 2;
   localparam int EVT_IDX_LSB = 0;

   typedef enum logic {
      SC_IDLE = 1'b0,
      SC_SCAN = 1'b1
   } scan_state_e;

endpackage

// File: rtl/nes_evt_fifo.sv
// Synchronous event FIFO with registered head, count and drop flag.
// Ports: push_i/data_i write, pop_i read, head_o/empty_o/count_o/drop_o.
module nes_evt_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int W     = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_o,
   output logic          empty_o,
   output logic [AW:0]   count_o,
   output logic          drop_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [W-1:0]  head_q, head_d;
   logic          full, wr_en, rd_en;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign rd_en   = pop_i & ~empty_o;
   // a pop frees the slot being written when full
   assign wr_en   = push_i & (~full | rd_en);
   assign drop_o  = push_i & full & ~rd_en;
   assign head_o  = head_q;
   assign count_o = cnt_q;

   always_comb begin
      rd_d   = rd_q + AW'(rd_en);
      cnt_d  = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      head_d = '0;
      if (cnt_d != '0) begin
         // bypass when the new entry becomes the head
         if (wr_en && (wr_q == rd_d))
            head_d = data_i;
         else
            head_d = mem_q[rd_d];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + AW'(1);
         end
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

endmodule

// File: rtl/nes_btn_events.sv
// Debounces NES controller frames and queues press/release events.
// Ports: nes_latch/nes_btns in, btn_state, evt_* handshake, overflow.
module nes_btn_events
   import nes_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 2,
   parameter int FIFO_DEPTH      = 8,
   parameter int FIFO_AW         = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               nes_latch,
   input  logic [7:0]         nes_btns,
   output logic [7:0]         btn_state,
   output logic               evt_valid,
   output logic [3:0]         evt_data,
   input  logic               evt_ready,
   output logic [FIFO_AW:0]   evt_count,
   output logic               overflow,
   input  logic               overflow_clr
);

   localparam logic [3:0] DB = 4'(DEBOUNCE_FRAMES);

   logic [1:0]  sync_q;
   logic        dly_q, pulse, busy, smp_v, accept;
   logic        pend_q, pend_d, acc_q, push_q, push_d;
   logic        ovf_q, ovf_d, pop, empty, drop;
   logic [7:0]  raw, smp, cand_q, cand_d, btn_q, btn_d;
   logic [7:0]  chg_q, chg_d, praw_q, praw_d;
   logic [3:0]  cnt_q, cnt_d, new_cnt, pdat_q, pdat_d;
   logic [2:0]  idx_q, idx_d;
   scan_state_e st_q, st_d;

   assign pulse = sync_q[1] & ~dly_q;
   assign raw   = ~nes_btns;
   // no sampling between accept and end of scan
   assign busy  = acc_q | (st_q == SC_SCAN);
   assign smp_v = ~busy & (pend_q | pulse);
   assign smp   = pend_q ? praw_q : raw;

   always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      praw_d  = praw_q;
      btn_d   = btn_q;
      chg_d   = chg_q;
      st_d    = st_q;
      idx_d   = idx_q;
      push_d  = 1'b0;
      pdat_d  = pdat_q;
      new_cnt = 4'd1;
      accept  = 1'b0;

      // pending wins over a fresh pulse; the pulse then becomes pending
      if (pulse && (busy || pend_q)) begin
         pend_d = 1'b1;
         praw_d = raw;
      end else if (smp_v && pend_q) begin
         pend_d = 1'b0;
      end

      if (smp_v) begin
         if (smp == cand_q)
            new_cnt = (cnt_q >= DB) ? DB : cnt_q + 4'd1;
         cand_d = smp;
         cnt_d  = new_cnt;
         accept = (new_cnt == DB) && (smp != btn_q);
      end

      unique case (st_q)
         SC_IDLE: begin
            if (acc_q) begin
               btn_d = cand_q;
               chg_d = cand_q ^ btn_q;
               idx_d = 3'd7;
               st_d  = SC_SCAN;
            end
         end
         SC_SCAN: begin
            push_d = chg_q[idx_q];
            pdat_d[EVT_PRESS] = btn_q[idx_q];
            pdat_d[EVT_IDX_MSB:EVT_IDX_LSB] = idx_q;
            idx_d = idx_q - 3'd1;
            if (idx_q == 3'd0)
               st_d = SC_IDLE;
         end
      endcase

      ovf_d = ovf_q;
      if (drop)
         ovf_d = 1'b1;
      else if (overflow_clr)
         ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
         cand_q <= '0;
         cnt_q  <= '0;
         acc_q  <= 1'b0;
         pend_q <= 1'b0;
         praw_q <= '0;
         btn_q  <= '0;
         chg_q  <= '0;
         st_q   <= SC_IDLE;
         idx_q  <= '0;
         push_q <= 1'b0;
         pdat_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], nes_latch};
         dly_q  <= sync_q[1];
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         acc_q  <= accept;
         pend_q <= pend_d;
         praw_q <= praw_d;
         btn_q  <= btn_d;
         chg_q  <= chg_d;
         st_q   <= st_d;
         idx_q  <= idx_d;
         push_q <= push_d;
         pdat_q <= pdat_d;
         ovf_q  <= ovf_d;
      end
   end

   assign pop = ~empty & evt_ready;

   nes_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW),
      .W     (4)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_q),
      .data_i  (pdat_q),
      .pop_i   (pop),
      .head_o  (evt_data),
      .empty_o (empty),
      .count_o (evt_count),
      .drop_o  (drop)
   );

   assign btn_state = btn_q;
   assign evt_valid = ~empty;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_nes_btn_events.sv
// Directed bench for nes_btn_events with an event scoreboard.
// Expected events are queued at stimulus time and checked on pop.
module tb_nes_btn_events;

   logic       clk = 1'b0;
   logic       reset;
   logic       nes_latch;
   logic [7:0] nes_btns;
   logic [7:0] btn_state;
   logic       evt_valid;
   logic [3:0] evt_data;
   logic       evt_ready;
   logic [3:0] evt_count;
   logic       overflow;
   logic       overflow_clr;

   int         ntests = 0;
   int         nfail  = 0;
   logic [3:0] sb[$];
   logic [3:0] exp_h;

   always #5 clk = ~clk;

   nes_btn_events #(
      .DEBOUNCE_FRAMES (2),
      .FIFO_DEPTH      (8),
      .FIFO_AW         (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .nes_latch    (nes_latch),
      .nes_btns     (nes_btns),
      .btn_state    (btn_state),
      .evt_valid    (evt_valid),
      .evt_data     (evt_data),
      .evt_ready    (evt_ready),
      .evt_count    (evt_count),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic latch_rise(input logic [7:0] b);
      @(posedge clk);
      #1;
      nes_btns  = b;
      nes_latch = 1'b1;
   endtask

   task automatic frame(input logic [7:0] b);
      latch_rise(b);
      repeat (3) @(posedge clk);
      #1 nes_latch = 1'b0;
      repeat (16) @(posedge clk);
   endtask

   task automatic rapid(input logic [7:0] b, input int n);
      nes_btns = b;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 nes_latch = 1'b1;
         @(posedge clk);
         #1 nes_latch = 1'b0;
      end
      repeat (20) @(posedge clk);
   endtask

   task automatic pop_check(input string tag);
      int n;
      logic [3:0] e;
      n = 0;
      @(negedge clk);
      while (!evt_valid && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, 8'(evt_valid), 8'd1);
      ntests++;
      assert (sb.size() != 0) else begin
         nfail++;
         $error("FAIL %s_sb: got empty scoreboard expected entry", tag);
      end
      e = (sb.size() != 0) ? sb.pop_front() : 4'h0;
      chk(tag, 8'(evt_data), 8'(e));
      evt_ready = 1'b1;
      @(posedge clk);
      #1 evt_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b0;
      nes_latch    = 1'b0;
      nes_btns     = 8'hFF;
      evt_ready    = 1'b0;
      overflow_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_btn", btn_state, 8'h00);
      chk("rst_valid", 8'(evt_valid), 8'd0);
      chk("rst_cnt", 8'(evt_count), 8'd0);
      chk("rst_data", 8'(evt_data), 8'h0);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (4) @(posedge clk);

      // single press with latency checks
      frame(8'h7F);
      latch_rise(8'h7F);
      sb.push_back(4'hF);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("lat_btn_pre", btn_state, 8'h00);
      @(negedge clk);
      chk("lat_btn", btn_state, 8'h80);
      @(negedge clk);
      chk("lat_valid_pre", 8'(evt_valid), 8'd0);
      @(negedge clk);
      chk("lat_valid", 8'(evt_valid), 8'd1);
      nes_latch = 1'b0;
      repeat (16) @(posedge clk);
      pop_check("press_a");
      @(negedge clk);
      chk("press_a_empty", 8'(evt_valid), 8'd0);

      // release A
      frame(8'hFF);
      frame(8'hFF);
      sb.push_back(4'h7);
      pop_check("rel_a");
      chk("rel_a_btn", btn_state, 8'h00);

      // glitch rejection
      frame(8'hFE);
      frame(8'hFF);
      frame(8'hFF);
      @(negedge clk);
      chk("glitch_btn", btn_state, 8'h00);
      chk("glitch_valid", 8'(evt_valid), 8'd0);

      // multi-button press then release
      frame(8'h7E);
      frame(8'h7E);
      sb.push_back(4'hF);
      sb.push_back(4'h8);
      @(negedge clk);
      chk("multi_cnt", 8'(evt_count), 8'd2);
      chk("multi_btn", btn_state, 8'h81);
      pop_check("multi_p7");
      pop_check("multi_p0");
      frame(8'hFF);
      frame(8'hFF);
      sb.push_back(4'h7);
      sb.push_back(4'h0);
      @(negedge clk);
      chk("multi_rcnt", 8'(evt_count), 8'd2);
      pop_check("multi_r7");
      pop_check("multi_r0");

      // overflow
      frame(8'h00);
      frame(8'h00);
      for (int i = 7; i >= 0; i--)
         sb.push_back({1'b1, 3'(i)});
      @(negedge clk);
      chk("full_cnt", 8'(evt_count), 8'd8);
      chk("full_ovf", 8'(overflow), 8'd0);
      frame(8'hC0);
      frame(8'hC0);
      @(negedge clk);
      chk("ovf_cnt", 8'(evt_count), 8'd8);
      chk("ovf_set", 8'(overflow), 8'd1);
      chk("ovf_btn", btn_state, 8'h3F);
      @(posedge clk);
      #1 overflow_clr = 1'b1;
      @(posedge clk);
      #1 overflow_clr = 1'b0;
      @(negedge clk);
      chk("ovf_clr", 8'(overflow), 8'd0);

      // push and pop together while full
      frame(8'hE0);
      latch_rise(8'hE0);
      repeat (7) @(posedge clk);
      #1;
      exp_h = sb.pop_front();
      chk("fullpp_head", 8'(evt_data), 8'(exp_h));
      evt_ready = 1'b1;
      @(posedge clk);
      #1 evt_ready = 1'b0;
      nes_latch = 1'b0;
      sb.push_back(4'h5);
      @(negedge clk);
      chk("fullpp_cnt", 8'(evt_count), 8'd8);
      chk("fullpp_ovf", 8'(overflow), 8'd0);
      repeat (16) @(posedge clk);
      @(negedge clk);
      chk("fullpp_cnt2", 8'(evt_count), 8'd8);
      for (int i = 0; i < 8; i++)
         pop_check($sformatf("drain%0d", i));
      @(negedge clk);
      chk("drain_empty", 8'(evt_valid), 8'd0);
      chk("drain_cnt", 8'(evt_count), 8'd0);

      // fast latch: samples land during scan
      rapid(8'hFF, 12);
      for (int i = 4; i >= 0; i--)
         sb.push_back({1'b0, 3'(i)});
      @(negedge clk);
      chk("fast_rcnt", 8'(evt_count), 8'd5);
      chk("fast_rbtn", btn_state, 8'h00);
      for (int i = 0; i < 5; i++)
         pop_check($sformatf("fast_r%0d", i));
      @(negedge clk);
      chk("fast_rempty", 8'(evt_valid), 8'd0);
      rapid(8'h7F, 12);
      sb.push_back(4'hF);
      @(negedge clk);
      chk("fast_pcnt", 8'(evt_count), 8'd1);
      chk("fast_pbtn", btn_state, 8'h80);
      chk("fast_phead", 8'(evt_data), 8'hF);

      // asynchronous reset with queued content
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_btn", btn_state, 8'h00);
      chk("arst_valid", 8'(evt_valid), 8'd0);
      chk("arst_cnt", 8'(evt_count), 8'd0);
      chk("arst_ovf", 8'(overflow), 8'd0);
      chk("arst_data", 8'(evt_data), 8'h0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("post_valid", 8'(evt_valid), 8'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
